// File: rtl/vic_pkg.sv
// vic_pkg: shared types and priority search for the vectored interrupt controller.
// vic_prio_sel walks downward from a start index, wrapping from 0 to n-1.
package vic_pkg;

   localparam int VIC_MAX_N = 16;

   typedef enum logic [1:0] {
      VIC_IDLE,
      VIC_ACK,
      VIC_WAIT
   } vic_state_t;

   // Returns {valid, index}; the lowest distance from start wins.
   function automatic logic [4:0] vic_prio_sel(
      input logic [VIC_MAX_N-1:0] mask,
      input logic [3:0]           start,
      input logic [4:0]           n
   );
      logic [4:0] res;
      logic [3:0] idx;
      res = '0;
      for (int d = VIC_MAX_N - 1; d >= 0; d--) begin
         if (5'(d) < n) begin
            if ({1'b0, start} >= 5'(d))
               idx = 4'({1'b0, start} - 5'(d));
            else
               idx = 4'({1'b0, start} + n - 5'(d));
            if (mask[idx])
               res = {1'b1, idx};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/vic_prio_enc.sv
// vic_prio_enc: N-input priority encoder with a rotating start index.
// Searches downward from start, wrapping from 0 to N-1.
module vic_prio_enc
   import vic_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0] req,
   input  logic [3:0]   start,
   output logic         valid,
   output logic [3:0]   idx
);

   logic [VIC_MAX_N-1:0] req_ext;

   assign req_ext      = VIC_MAX_N'(req);
   assign {valid, idx} = vic_prio_sel(req_ext, start, 5'(N));

endmodule

// File: rtl/vic_wb_multi.sv
// vic_wb_multi: N-channel vectored interrupt controller for the VM1 bus.
// Define VIC_ROUND_ROBIN_EN for rotating priority; fixed priority otherwise.
module vic_wb_multi
   import vic_pkg::*;
#(
   parameter int          N        = 2,
   parameter logic [N-1:0] EDGE    = '0,
   parameter logic [15:0] SPURIOUS = 16'o000000
) (
   input  logic          clk_sys,
   input  logic          wb_rst_i,
   input  logic          ce,
   input  logic [16*N-1:0] ivec,
   input  logic [N-1:0]  ireq,
   input  logic [N-1:0]  imask,
   output logic [N-1:0]  iack,
   input  logic          wb_stb_i,
   output logic          wb_ack_o,
   output logic [15:0]   wb_dat_o,
   output logic          wb_irq_o
);

   vic_state_t   state_q, state_d;
   logic         deliver;
   logic [N-1:0] pend, pend_d, ireq_q;
   logic [N-1:0] act, win_oh, clr;
   logic         win_valid;
   logic [3:0]   win_idx, start;
   logic [15:0]  win_vec;

   assign act = pend & ~imask;

`ifdef VIC_ROUND_ROBIN_EN
   logic [3:0] ptr;

   // Search starts just below the last delivered channel.
   assign start = (ptr == 4'd0) ? 4'(N - 1) : ptr - 4'd1;

   always_ff @(posedge clk_sys or posedge wb_rst_i)
      if (wb_rst_i)
         ptr <= '0;
      else if (ce && deliver && win_valid)
         ptr <= win_idx;
`else
   assign start = 4'(N - 1);
`endif

   vic_prio_enc #(.N(N)) u_prio (
      .req   (act),
      .start (start),
      .valid (win_valid),
      .idx   (win_idx)
   );

   always_comb begin
      win_oh  = '0;
      win_vec = SPURIOUS;
      for (int i = 0; i < N; i++)
         if (win_valid && win_idx == 4'(i)) begin
            win_oh[i] = 1'b1;
            win_vec   = ivec[16*i +: 16];
         end
   end

   always_comb begin
      state_d = state_q;
      deliver = 1'b0;
      case (state_q)
         VIC_IDLE:
            if (wb_stb_i) begin
               state_d = VIC_ACK;
               deliver = 1'b1;
            end
         VIC_ACK:
            state_d = wb_stb_i ? VIC_WAIT : VIC_IDLE;
         VIC_WAIT:
            if (!wb_stb_i)
               state_d = VIC_IDLE;
         default:
            state_d = VIC_IDLE;
      endcase
   end

   // A fresh edge in the delivery cycle outranks the clear.
   assign clr    = deliver ? (win_oh & EDGE) : '0;
   assign pend_d = (EDGE & ((ireq & ~ireq_q) | (pend & ~clr)))
                 | (~EDGE & ireq);

   always_ff @(posedge clk_sys or posedge wb_rst_i)
      if (wb_rst_i) begin
         state_q  <= VIC_IDLE;
         pend     <= '0;
         ireq_q   <= '0;
         iack     <= '0;
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
         wb_irq_o <= 1'b0;
      end else if (ce) begin
         state_q  <= state_d;
         pend     <= pend_d;
         ireq_q   <= ireq;
         wb_irq_o <= |act;
         iack     <= deliver ? win_oh : '0;
         if (deliver) begin
            wb_ack_o <= 1'b1;
            wb_dat_o <= win_vec;
         end else if (state_d == VIC_IDLE) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
         end
      end

endmodule

// File: tb/tb_vic_wb_multi.sv
// tb_vic_wb_multi: directed scenarios plus a randomized run against a reference model.
// Four channels; channel 1 is edge-triggered, the rest are level.
module tb_vic_wb_multi;

   localparam int          N    = 4;
   localparam logic [3:0]  EDGP = 4'b0010;
   localparam logic [15:0] SPUR = 16'o000777;

   logic        clk = 1'b0;
   logic        rst, ce, stb;
   logic [3:0]  ireq, imask, iack;
   logic        ack, irq;
   logic [15:0] dat;
   logic [15:0] vtab [4];
   logic [63:0] ivec;

   int tests = 0;
   int fails = 0;

   assign ivec = {vtab[3], vtab[2], vtab[1], vtab[0]};

   vic_wb_multi #(.N(N), .EDGE(EDGP), .SPURIOUS(SPUR)) dut (
      .clk_sys  (clk),
      .wb_rst_i (rst),
      .ce       (ce),
      .ivec     (ivec),
      .ireq     (ireq),
      .imask    (imask),
      .iack     (iack),
      .wb_stb_i (stb),
      .wb_ack_o (ack),
      .wb_dat_o (dat),
      .wb_irq_o (irq)
   );

   always #5 clk = ~clk;

   // Reference model: spec rules evaluated per ce edge with plain integers.
   logic [3:0]  m_pend, m_prev, m_iack;
   logic        m_busy, m_ack, m_irq;
   logic [15:0] m_dat;
   int          m_ptr;

   always @(posedge clk or posedge rst) begin : model
      int start, idx, widx;
      bit valid, dlv;
      logic [3:0] np;
      if (rst) begin
         m_pend <= '0; m_prev <= '0; m_iack <= '0;
         m_busy <= 1'b0; m_ack <= 1'b0; m_irq <= 1'b0;
         m_dat <= '0; m_ptr <= 0;
      end else if (ce) begin
`ifdef VIC_ROUND_ROBIN_EN
         start = (m_ptr == 0) ? N - 1 : m_ptr - 1;
`else
         start = N - 1;
`endif
         valid = 0;
         widx = 0;
         for (int d = 0; d < N; d++) begin
            idx = (start - d + N) % N;
            if (!valid && m_pend[idx] && !imask[idx]) begin
               valid = 1;
               widx = idx;
            end
         end
         dlv = !m_busy && stb;
         for (int i = 0; i < N; i++)
            if (EDGP[i])
               np[i] = (ireq[i] && !m_prev[i])
                     || (m_pend[i] && !(dlv && valid && widx == i));
            else
               np[i] = ireq[i];
         m_pend <= np;
         m_prev <= ireq;
         m_irq  <= |(m_pend & ~imask);
         m_iack <= (dlv && valid) ? 4'(1 << widx) : 4'b0;
         if (dlv) begin
            m_busy <= 1'b1;
            m_ack  <= 1'b1;
            m_dat  <= valid ? vtab[widx] : SPUR;
            if (valid) m_ptr <= widx;
         end else if (!stb) begin
            m_busy <= 1'b0;
            m_ack  <= 1'b0;
            m_dat  <= '0;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; ce = 1'b1; stb = 1'b0;
      imask = '0; ireq = 4'b0010;
      cyc(2);
      tests++;
      if ({ack, dat, iack, irq} !== 22'b0) begin
         fails++;
         $display("FAIL reset_outputs: ack=%b dat=%o iack=%b irq=%b want all 0",
                  ack, dat, iack, irq);
      end
      rst = 1'b0;
      cyc(2);
      tests++;
      if (irq !== 1'b1) begin
         fails++;
         $display("FAIL reset_held_edge_irq: got %b want 1", irq);
      end
      stb = 1'b1;
      cyc(1);
      tests++;
      if (iack !== 4'b0010 || dat !== 16'o000060) begin
         fails++;
         $display("FAIL reset_held_edge_ack: iack=%b dat=%o want 0010/060", iack, dat);
      end
      stb = 1'b0; ireq = '0;
      cyc(1);
      tests++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL reset_edge_cleared_irq: got %b want 0", irq);
      end
      cyc(1);
   endtask

   task automatic test_level();
      ireq = 4'b0001;
      cyc(1);
      tests++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL level_irq_1cyc: got %b want 0", irq);
      end
      cyc(1);
      tests++;
      if (irq !== 1'b1) begin
         fails++;
         $display("FAIL level_irq_2cyc: got %b want 1", irq);
      end
      stb = 1'b1;
      cyc(1);
      tests++;
      if (ack !== 1'b1 || dat !== 16'o000274 || iack !== 4'b0001) begin
         fails++;
         $display("FAIL level_ack: ack=%b dat=%o iack=%b want 1/274/0001", ack, dat, iack);
      end
      cyc(1);
      tests++;
      if (ack !== 1'b1 || dat !== 16'o000274 || iack !== 4'b0000) begin
         fails++;
         $display("FAIL level_wait: ack=%b dat=%o iack=%b want 1/274/0000", ack, dat, iack);
      end
      stb = 1'b0;
      cyc(1);
      tests++;
      if (ack !== 1'b0 || dat !== 16'o0) begin
         fails++;
         $display("FAIL level_release: ack=%b dat=%o want 0/0", ack, dat);
      end
      ireq = '0;
      cyc(2);
   endtask

   task automatic test_priority();
      ireq = 4'b0011;
      cyc(2);
      stb = 1'b1;
      cyc(1);
      tests++;
      if (dat !== 16'o000060 || iack !== 4'b0010) begin
         fails++;
         $display("FAIL prio_first: dat=%o iack=%b want 060/0010", dat, iack);
      end
      stb = 1'b0;
      cyc(1);
      ireq = 4'b0001;
      cyc(1);
      stb = 1'b1;
      cyc(1);
      tests++;
      if (dat !== 16'o000274 || iack !== 4'b0001) begin
         fails++;
         $display("FAIL prio_second: dat=%o iack=%b want 274/0001", dat, iack);
      end
      stb = 1'b0; ireq = '0;
      cyc(2);
   endtask

   task automatic test_edge_mask();
      imask = 4'b0010; ireq = 4'b0010;
      cyc(1);
      ireq = '0;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         tests++;
         if (irq !== 1'b0) begin
            fails++;
            $display("FAIL edge_masked_irq[%0d]: got %b want 0", k, irq);
         end
      end
      imask = '0;
      cyc(1);
      tests++;
      if (irq !== 1'b1) begin
         fails++;
         $display("FAIL edge_unmasked_irq: got %b want 1", irq);
      end
      stb = 1'b1;
      cyc(1);
      tests++;
      if (dat !== 16'o000060 || iack !== 4'b0010) begin
         fails++;
         $display("FAIL edge_ack: dat=%o iack=%b want 060/0010", dat, iack);
      end
      cyc(1);
      tests++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL edge_cleared_irq: got %b want 0", irq);
      end
      stb = 1'b0;
      cyc(1);
   endtask

   task automatic test_spurious();
      stb = 1'b1;
      cyc(1);
      tests++;
      if (ack !== 1'b1 || dat !== SPUR || iack !== 4'b0) begin
         fails++;
         $display("FAIL spurious: ack=%b dat=%o iack=%b want 1/%o/0000", ack, dat, iack, SPUR);
      end
      stb = 1'b0;
      cyc(1);
      tests++;
      if (ack !== 1'b0 || dat !== 16'o0) begin
         fails++;
         $display("FAIL spurious_release: ack=%b dat=%o want 0/0", ack, dat);
      end
   endtask

   task automatic test_reset_mid();
      ireq = 4'b0001;
      cyc(2);
      stb = 1'b1;
      cyc(2);
      tests++;
      if (ack !== 1'b1) begin
         fails++;
         $display("FAIL rstmid_wait_ack: got %b want 1", ack);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({ack, dat, iack, irq} !== 22'b0) begin
         fails++;
         $display("FAIL rstmid_async: ack=%b dat=%o iack=%b irq=%b want all 0",
                  ack, dat, iack, irq);
      end
      stb = 1'b0; ireq = '0;
      cyc(2);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         tests++;
         if (iack !== 4'b0 || ack !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_after[%0d]: iack=%b ack=%b want 0000/0", k, iack, ack);
         end
      end
   endtask

   task automatic test_round_robin();
      int exp;
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      ireq = 4'b1111;
      cyc(2);
      for (int k = 0; k < 4; k++) begin
`ifdef VIC_ROUND_ROBIN_EN
         exp = 3 - k;
`else
         exp = 3;
`endif
         stb = 1'b1;
         cyc(1);
         tests++;
         if (iack !== 4'(1 << exp) || dat !== vtab[exp]) begin
            fails++;
            $display("FAIL rr_round[%0d]: iack=%b dat=%o want ch%0d/%o",
                     k, iack, dat, exp, vtab[exp]);
         end
         stb = 1'b0;
         cyc(1);
      end
      ireq = '0;
      cyc(2);
   endtask

   task automatic test_random();
      for (int k = 0; k < 800; k++) begin
         ce = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) ireq = 4'($urandom);
         if ($urandom_range(0, 7) == 0) imask = 4'($urandom);
         if ($urandom_range(0, 2) == 0) stb = ~stb;
         cyc(1);
         tests++;
         if ({ack, dat, iack, irq} !== {m_ack, m_dat, m_iack, m_irq}) begin
            fails++;
            $display("FAIL random[%0d]: ack=%b dat=%o iack=%b irq=%b want %b/%o/%b/%b",
                     k, ack, dat, iack, irq, m_ack, m_dat, m_iack, m_irq);
         end
      end
      ce = 1'b1; stb = 1'b0;
   endtask

   initial begin
      vtab[0] = 16'o000274;
      vtab[1] = 16'o000060;
      vtab[2] = 16'o000100;
      vtab[3] = 16'o000120;
      test_reset();
      test_level();
      test_priority();
      test_edge_mask();
      test_spurious();
      test_reset_mid();
      test_round_robin();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
